// File: rtl/seg7_hex_encoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_encoder
//
// Turns a stream of active-low DE10-Lite seven-segment patterns back into hex
// digits. Each handshake delivers one digit; six digits (HEX5 first, HEX0 last)
// are packed into a 24-bit word. The block also records which digits carried an
// unrecognised pattern and which had the decimal point lit.
//
// Ports
//   MAX10_CLK1_50  in   1        system clock, rising edge
//   RST_N          in   1        asynchronous active-low reset
//   SEG_IN         in   8        pattern, active-low; [7]=DP, [6:0]=g..a
//   SEG_VALID      in   1        SEG_IN valid this cycle
//   SEG_READY      out  1        a digit is accepted this cycle if SEG_VALID
//   FRAME_CLR      in   1        synchronous frame abort (highest priority)
//   WORD_OUT       out  4*NDIG   assembled value, HEX5 in the top nibble
//   ERR_MASK       out  NDIG     bit i = HEX i pattern invalid
//   DP_MASK        out  NDIG     bit i = HEX i decimal point lit
//   WORD_VALID     out  1        completed frame is being held
//   WORD_READY     in   1        consumer takes the held frame
//   DIGIT_IDX      out  3        digits accepted so far in the current frame
// -----------------------------------------------------------------------------
module seg7_hex_encoder #(
  parameter int NDIG = 6
) (
  input  logic                MAX10_CLK1_50,
  input  logic                RST_N,
  input  logic [7:0]          SEG_IN,
  input  logic                SEG_VALID,
  output logic                SEG_READY,
  input  logic                FRAME_CLR,
  output logic [4*NDIG-1:0]   WORD_OUT,
  output logic [NDIG-1:0]     ERR_MASK,
  output logic [NDIG-1:0]     DP_MASK,
  output logic                WORD_VALID,
  input  logic                WORD_READY,
  output logic [2:0]          DIGIT_IDX
);

  localparam int WW = 4 * NDIG;

  // Active-high glyphs for 0..F, index = hex value.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Pattern decode
  // ---------------------------------------------------------------------------
  logic [6:0]  w_pat;
  logic [15:0] w_hit;
  logic [3:0]  w_nib;
  logic        w_err;
  logic        w_dp;

  assign w_pat = ~SEG_IN[6:0];
  assign w_dp  = ~SEG_IN[7];

  // One comparator per glyph; the glyphs are distinct so at most one hits.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_match
      assign w_hit[gi] = (w_pat == GLYPH[gi]);
    end
  endgenerate

  // One-hot to binary. An unmatched pattern yields zero, which is exactly the
  // nibble wanted for an invalid digit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_enc
      logic [15:0] w_sel;
      for (genvar gk = 0; gk < 16; gk++) begin : g_sel
        assign w_sel[gk] = w_hit[gk] & ((gk >> gi) & 1) != 0;
      end
      assign w_nib[gi] = |w_sel;
    end
  endgenerate

  assign w_err = ~|w_hit;

  // ---------------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic              r_seg_ready;
  logic              r_word_valid;
  logic [WW-1:0]     r_word;
  logic [NDIG-1:0]   r_err;
  logic [NDIG-1:0]   r_dp;
  logic [2:0]        r_idx;

  logic              w_accept;
  logic              w_first;
  logic              w_last;
  logic [WW-1:0]     w_word_next;
  logic [NDIG-1:0]   w_err_next;
  logic [NDIG-1:0]   w_dp_next;

  assign w_accept = SEG_VALID & r_seg_ready;
  assign w_first  = (r_idx == 3'd0);
  assign w_last   = (r_idx == 3'(NDIG - 1));

  // The first digit of a frame loads fresh instead of shifting, so nothing
  // from the previous frame (or an aborted partial frame) survives into the
  // new word even while it is still being assembled.
  assign w_word_next = w_first ? {{(WW-4){1'b0}}, w_nib}
                               : {r_word[WW-5:0], w_nib};
  assign w_err_next  = w_first ? {{(NDIG-1){1'b0}}, w_err}
                               : {r_err[NDIG-2:0], w_err};
  assign w_dp_next   = w_first ? {{(NDIG-1){1'b0}}, w_dp}
                               : {r_dp[NDIG-2:0], w_dp};

  // Handshake flags are kept as their own flops, updated alongside the state,
  // so neither has a combinational path from SEG_VALID or WORD_READY.
  always_ff @(posedge MAX10_CLK1_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_COLLECT;
      r_seg_ready  <= 1'b1;
      r_word_valid <= 1'b0;
      r_word       <= '0;
      r_err        <= '0;
      r_dp         <= '0;
      r_idx        <= '0;
    end else if (FRAME_CLR) begin
      // Abort wins over both an accept and a consumer take. The data
      // registers keep their contents; the next accept reloads them.
      r_state      <= S_COLLECT;
      r_seg_ready  <= 1'b1;
      r_word_valid <= 1'b0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            r_word <= w_word_next;
            r_err  <= w_err_next;
            r_dp   <= w_dp_next;
            if (w_last) begin
              r_idx        <= '0;
              r_state      <= S_HOLD;
              r_seg_ready  <= 1'b0;
              r_word_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_HOLD: begin
          // Everything stays frozen until the consumer takes the word.
          if (WORD_READY) begin
            r_state      <= S_COLLECT;
            r_seg_ready  <= 1'b1;
            r_word_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_COLLECT;
          r_seg_ready  <= 1'b1;
          r_word_valid <= 1'b0;
          r_idx        <= '0;
        end
      endcase
    end
  end

  assign SEG_READY  = r_seg_ready;
  assign WORD_VALID = r_word_valid;
  assign WORD_OUT   = r_word;
  assign ERR_MASK   = r_err;
  assign DP_MASK    = r_dp;
  assign DIGIT_IDX  = r_idx;

endmodule

// File: doc/seg7_hex_encoder.md
# seg7_hex_encoder

Reverse of the board's hex-to-7-segment decode path: accepts a stream of active-low DE10-Lite segment patterns, one digit per handshake, converts each back to its 4-bit hex value and assembles six digits (HEX5 first, HEX0 last) into a 24-bit word. It sits between a segment-pattern source (display mirror, capture logic or test stimulus) and any logic that needs the numeric value. It also reports which digits carried an unrecognised pattern and which had the decimal point lit.

## Interface
Parameters:
- NDIG, 6, digits per frame (fixed at 6 for this block; word width = 4*NDIG).

Ports:
- MAX10_CLK1_50  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SEG_IN  in  8  segment pattern, active-low; bit7 = DP, bits6..0 = g..a.
- SEG_VALID  in  1  SEG_IN valid this cycle.
- SEG_READY  out  1  block accepts a digit this cycle.
- FRAME_CLR  in  1  synchronous frame abort.
- WORD_OUT  out  24  assembled value; HEX5 digit in [23:20], HEX0 digit in [3:0].
- ERR_MASK  out  6  bit i set = HEX i pattern invalid.
- DP_MASK  out  6  bit i set = HEX i decimal point lit.
- WORD_VALID  out  1  frame result available.
- WORD_READY  in  1  consumer takes the frame.
- DIGIT_IDX  out  3  digits accepted so far in the current frame (0..5).

## Operation
- Decode: invert SEG_IN[6:0]. Active-high patterns 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 map to 0..F. Any other pattern, including blank, gives nibble 0 and sets the digit's error bit. DP is ignored for value. DP lit means SEG_IN[7]=0.
- Accept when SEG_VALID and SEG_READY are both high. On accept:
  - WORD_OUT shifts left 4 and the nibble enters [3:0].
  - ERR_MASK and DP_MASK shift left 1 and the new bit enters bit0.
  - DIGIT_IDX increments.
- FSM states:
  - COLLECT: SEG_READY=1, WORD_VALID=0. An accept with DIGIT_IDX=5 moves to HOLD and sets DIGIT_IDX to 0.
  - HOLD: SEG_READY=0, WORD_VALID=1, all outputs frozen. WORD_READY=1 returns to COLLECT next cycle.
- At the first accept of a new frame, WORD_OUT, ERR_MASK and DP_MASK load fresh. The previous frame's contents never leak into the new word.
- FRAME_CLR, in either state: next state COLLECT, DIGIT_IDX=0, WORD_VALID=0. A digit presented in the same cycle is discarded. FRAME_CLR has priority over accept and over WORD_READY.
- SEG_VALID high in HOLD is not an accept. The source must hold the digit until SEG_READY is high.

## Timing
- Reset values: WORD_OUT=0, ERR_MASK=0, DP_MASK=0, DIGIT_IDX=0, WORD_VALID=0, SEG_READY=1 (state COLLECT).
- Reset mid-frame discards all partial digits immediately (asynchronous).
- Accept in cycle N updates the registers at the edge ending cycle N.
- The sixth accept in cycle N gives WORD_VALID=1 from cycle N+1.
- WORD_READY high in cycle M (state HOLD) gives WORD_VALID=0 and SEG_READY=1 in cycle M+1. There is no same-cycle bypass.
- Peak throughput is one digit per cycle, with one dead cycle per frame minimum (HOLD lasts at least 1 cycle).
- SEG_READY and WORD_VALID are registered state decodes. They have no combinational path from SEG_VALID or WORD_READY.

## Test plan
- Reset then six back-to-back digits C0,F9,A4,B0,99,92 (0..5), WORD_READY=0 → WORD_VALID rises the cycle after the sixth accept, WORD_OUT=0x012345, ERR_MASK=0, DP_MASK=0, SEG_READY=0 while held.
- Frame 88,83,C6,A1,86,8E (A,b,C,d,E,F), WORD_READY held high → WORD_OUT=0xABCDEF, WORD_VALID high exactly 1 cycle, SEG_READY returns the following cycle.
- Frame with HEX3 digit=FF and HEX0 digit=40 (0 with DP lit) → WORD_OUT nibble [15:12]=0, ERR_MASK=6'b001000, DP_MASK=6'b000001.
- Three digits accepted, then FRAME_CLR asserted together with SEG_VALID → DIGIT_IDX=0 and the concurrent digit dropped. Next six digits F9×6 give WORD_OUT=0x111111.
- In HOLD, SEG_VALID held high with a new digit → no accept, outputs unchanged. After WORD_READY, that digit is accepted as the first of the new frame.
- Assert RST_N=0 asynchronously after four accepts → all outputs return to reset values without a clock edge. A full frame afterwards decodes correctly.
